// File: rtl/reg_bank_load_sequencer.sv
// reg_bank_load_sequencer
// Fills a bank of K external load-enable registers from one N-bit word stream.
// The first accepted word goes to register 0, and each later word goes to the
// next register in order.
// A full frame is presented downstream with a valid/ready handshake.
// An inter-word timeout abandons a frame when the producer stalls.
module reg_bank_load_sequencer #(
  parameter int N       = 8,
  parameter int K       = 4,
  parameter int IW      = 2,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic [N-1:0]  in_data,
  output logic          in_ready,
  output logic [N-1:0]  d_bus,
  output logic [K-1:0]  load_en,
  output logic [IW-1:0] word_idx,
  output logic          frame_valid,
  input  logic          frame_ready,
  output logic          busy,
  output logic          err_timeout,
  output logic [7:0]    frame_cnt
);

  // Wide enough to hold TIMEOUT itself.
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  logic [1:0]    state_reg, state_next;
  logic [IW-1:0] idx_reg, idx_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic          err_reg, err_next;
  logic [7:0]    cnt_reg, cnt_next;

  logic accept;
  logic last_word;
  logic timed_out;

  assign in_ready    = (state_reg == S_CAPTURE);
  assign accept      = in_valid & in_ready;
  assign last_word   = (idx_reg == IW'(K - 1));
  assign timed_out   = (timer_reg == TW'(TIMEOUT - 1));

  // The bus is a plain pass-through.
  // The bank register picked by load_en captures in_data on the same edge
  // that accepts it.
  assign d_bus       = in_data;
  assign word_idx    = idx_reg;
  assign frame_valid = (state_reg == S_DONE);
  assign busy        = (state_reg != S_IDLE);
  assign err_timeout = err_reg;
  assign frame_cnt   = cnt_reg;

  // One-hot decode of the current index, gated by accept.
  // This gating keeps load_en low outside CAPTURE.
  genvar gi;
  generate
    for (gi = 0; gi < K; gi++) begin : g_load_en
      assign load_en[gi] = accept && (idx_reg == IW'(gi));
    end
  endgenerate

  // Next-state logic for the IDLE -> CAPTURE -> DONE sequence and its bookkeeping.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    timer_next = timer_reg;
    err_next   = err_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = S_CAPTURE;
          idx_next   = '0;
          timer_next = '0;
          err_next   = 1'b0;
        end
      end
      S_CAPTURE: begin
        if (accept) begin
          // An accept wins over a timeout that expires in the same cycle.
          timer_next = '0;
          if (last_word) begin
            idx_next   = '0;
            state_next = S_DONE;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end else if (timed_out) begin
          state_next = S_IDLE;
          err_next   = 1'b1;
          idx_next   = '0;
          timer_next = '0;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      S_DONE: begin
        if (frame_ready) begin
          state_next = S_IDLE;
          cnt_next   = cnt_reg + 8'd1;
        end
      end
      default: begin
        state_next = S_IDLE;
        idx_next   = '0;
        timer_next = '0;
      end
    endcase
  end

  // State registers.
  // Reset is asynchronous so that a reset in the middle of a frame drops the
  // outputs immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      idx_reg   <= '0;
      timer_reg <= '0;
      err_reg   <= 1'b0;
      cnt_reg   <= 8'd0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      timer_reg <= timer_next;
      err_reg   <= err_next;
      cnt_reg   <= cnt_next;
    end
  end

endmodule

// File: tb/tb_reg_bank_load_sequencer.sv
// Testbench for reg_bank_load_sequencer (N=8, K=4, TIMEOUT=5).
// A behavioural bank model captures d_bus on load_en.
// Expected frames are queued as they are driven.
// Each queued frame is popped and compared with the bank when the frame is handed off.
module tb_reg_bank_load_sequencer;

  localparam int N  = 8;
  localparam int K  = 4;
  localparam int IW = 2;
  localparam int TO = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic [N-1:0]  in_data;
  logic          in_ready;
  logic [N-1:0]  d_bus;
  logic [K-1:0]  load_en;
  logic [IW-1:0] word_idx;
  logic          frame_valid;
  logic          frame_ready;
  logic          busy;
  logic          err_timeout;
  logic [7:0]    frame_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_cnt  = 0;

  logic [N*K-1:0] sb_q[$];
  logic [N-1:0]   bank [K];

  reg_bank_load_sequencer #(.N(N), .K(K), .IW(IW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .d_bus(d_bus), .load_en(load_en), .word_idx(word_idx),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .busy(busy),
    .err_timeout(err_timeout), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // External hold-register bank: each register loads d_bus when its enable is high.
  always @(posedge clk) begin
    for (int k = 0; k < K; k++)
      if (load_en[k]) bank[k] <= d_bus;
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg;
    @(negedge clk);
  endtask

  function automatic logic [31:0] idle_vec();
    return {16'd0, busy, in_ready, load_en, frame_valid, word_idx, err_timeout, frame_cnt};
  endfunction

  // Drive one frame.
  // Insert `gap` idle cycles before each word, then check frame_valid.
  task automatic send_frame(input logic [N*K-1:0] words, input int gap);
    sb_q.push_back(words);
    start = 1'b1;
    at_neg;
    check_val("start_idle_busy", busy, 0);
    tick;
    start = 1'b0;
    for (int i = 0; i < K; i++) begin
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        at_neg;
        check_val("gap_load_en", load_en, 0);
        check_val("gap_in_ready", in_ready, 1);
        tick;
      end
      in_valid = 1'b1;
      in_data  = words[i*N +: N];
      at_neg;
      check_val("load_en", load_en, 32'(1) << i);
      check_val("word_idx", word_idx, i);
      check_val("d_bus", d_bus, words[i*N +: N]);
      tick;
    end
    in_valid = 1'b0;
    at_neg;
    check_val("frame_valid_rise", frame_valid, 1);
    tick;
  endtask

  // Hold off the consumer for `bp` cycles while start and in_valid toggle.
  // Then pop the scoreboard, compare the bank, and complete the handshake.
  task automatic recv_frame(input int bp);
    logic [N*K-1:0] exp_words;
    for (int c = 0; c < bp; c++) begin
      start    = c[0];
      in_valid = c[1];
      in_data  = N'($urandom);
      at_neg;
      check_val("bp_frame_valid", frame_valid, 1);
      check_val("bp_in_ready", in_ready, 0);
      check_val("bp_load_en", load_en, 0);
      check_val("bp_frame_cnt", frame_cnt, exp_cnt[7:0]);
      tick;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    if (sb_q.size() == 0) begin
      check_val("sb_nonempty", 0, 1);
    end else begin
      exp_words = sb_q.pop_front();
      check_val("bank", {bank[3], bank[2], bank[1], bank[0]}, exp_words);
    end
    frame_ready = 1'b1;
    at_neg;
    check_val("hs_frame_valid", frame_valid, 1);
    check_val("hs_no_err", err_timeout, 0);
    tick;
    frame_ready = 1'b0;
    exp_cnt++;
    at_neg;
    check_val("frame_cnt", frame_cnt, exp_cnt[7:0]);
    check_val("post_hs_busy", busy, 0);
    tick;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; frame_ready = 1'b0;
    #12 rst = 1'b0;
    tick;

    // Reset then idle: everything quiet for 10 cycles.
    for (int c = 0; c < 10; c++) begin
      at_neg;
      check_val("reset_idle", idle_vec(), 0);
      tick;
    end

    // Back-to-back frame, then a gapped producer frame.
    send_frame({8'h44, 8'h33, 8'h22, 8'h11}, 0);
    recv_frame(0);
    send_frame({8'hD4, 8'hC3, 8'hB2, 8'hA1}, 3);
    recv_frame(0);

    // Consumer backpressure for 20 cycles.
    send_frame({8'h5A, 8'hF0, 8'h0F, 8'hA5}, 0);
    recv_frame(20);

    // Timeout: one word, then the producer stalls.
    start = 1'b1;
    tick;
    start = 1'b0;
    in_valid = 1'b1; in_data = 8'hAA;
    at_neg;
    check_val("to_first_load", load_en, 1);
    tick;
    in_valid = 1'b0;
    for (int c = 0; c < TO; c++) begin
      at_neg;
      check_val("to_busy_wait", busy, 1);
      check_val("to_no_frame_valid", frame_valid, 0);
      tick;
    end
    at_neg;
    check_val("to_idle", busy, 0);
    check_val("to_err_set", err_timeout, 1);
    check_val("to_word_idx", word_idx, 0);
    tick;
    start = 1'b1;
    at_neg;
    check_val("to_err_sticky", err_timeout, 1);
    tick;
    start = 1'b0;
    at_neg;
    check_val("to_err_cleared", err_timeout, 0);
    check_val("to_restart_busy", busy, 1);
    tick;
    repeat (TO + 1) tick;

    // Asynchronous reset between the 2nd and 3rd word.
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = N'(8'h60 + i);
      tick;
    end
    in_valid = 1'b1; in_data = 8'h62;
    #2 rst = 1'b1;
    #1;
    check_val("async_rst_outputs", idle_vec(), 0);
    exp_cnt = 0;
    #1 rst = 1'b0;
    in_valid = 1'b0;
    tick;
    send_frame({8'h04, 8'h03, 8'h02, 8'h01}, 0);
    recv_frame(0);

    // Run frames until frame_cnt wraps from 255 to 0.
    for (int f = 0; f < 255; f++) begin
      send_frame({N'($urandom), N'($urandom), N'($urandom), N'($urandom)}, 0);
      recv_frame(0);
    end
    at_neg;
    check_val("frame_cnt_wrap", frame_cnt, 0);
    tick;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
